// File: rtl/pmem_rr_arbiter.sv
// Shares one physical-memory line port among NUM_PORTS cache requesters,
// using round-robin or fixed (port 0 first) arbitration.
module pmem_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0,
    localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    output logic [LINE_W-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [ADDR_W-1:0]           pmem_address,
    output logic [LINE_W-1:0]           pmem_wdata,
    output logic                        pmem_read,
    output logic                        pmem_write,
    input  logic [LINE_W-1:0]           pmem_rdata,
    input  logic                        pmem_resp,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;

    logic [NUM_PORTS-1:0] w_reqv;
    logic [ID_W-1:0]      w_base;
    logic [ID_W-1:0]      w_win;
    logic                 w_found;

    function automatic logic [ID_W-1:0] f_wrap(
        input logic [ID_W-1:0] base,
        input int              d
    );
        int k;
        k = int'(base) + d;
        if (k >= NUM_PORTS) k = k - NUM_PORTS;
        return ID_W'(k);
    endfunction

    assign req_rdata = pmem_rdata;
    assign busy      = (r_state == S_BUSY);

    always_comb begin
        req_resp = '0;
        if (r_state == S_BUSY && pmem_resp) req_resp[grant_id] = 1'b1;
    end

    assign w_reqv = (req_read | req_write) & ~req_resp;

    // Fixed priority is the round-robin search anchored at port 0.
    assign w_base = (PRIO_MODE == 1) ? '0 : r_rr_ptr;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int d = 0; d < NUM_PORTS; d++) begin
            if (!w_found && w_reqv[f_wrap(w_base, d)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(w_base, d);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            grant_id     <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        pmem_address <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                        pmem_wdata   <= req_wdata[int'(w_win)*LINE_W +: LINE_W];
                        // Write takes precedence when a port raises both.
                        pmem_write   <= req_write[w_win];
                        pmem_read    <= ~req_write[w_win];
                        grant_id     <= w_win;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        r_rr_ptr   <= f_wrap(grant_id, 1);
                        r_state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// Bench for pmem_rr_arbiter: directed scenarios plus randomized traffic
// against a queue-free transaction model, and a fixed-priority instance.
module tb_pmem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_wdata;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [LW-1:0]   req_rdata;
    logic [N-1:0]    req_resp;
    logic [AW-1:0]   pmem_address;
    logic [LW-1:0]   pmem_wdata;
    logic            pmem_read;
    logic            pmem_write;
    logic [LW-1:0]   pmem_rdata;
    logic            pmem_resp;
    logic            busy;
    logic [1:0]      grant_id;

    logic [N*AW-1:0] f_req_addr;
    logic [N*LW-1:0] f_req_wdata;
    logic [N-1:0]    f_req_read;
    logic [N-1:0]    f_req_write;
    logic [LW-1:0]   f_req_rdata;
    logic [N-1:0]    f_req_resp;
    logic [AW-1:0]   f_pmem_address;
    logic [LW-1:0]   f_pmem_wdata;
    logic            f_pmem_read;
    logic            f_pmem_write;
    logic [LW-1:0]   f_pmem_rdata;
    logic            f_pmem_resp;
    logic            f_busy;
    logic [1:0]      f_grant_id;

    always #5 clk = ~clk;

    pmem_rr_arbiter #(
        .NUM_PORTS(N), .LINE_W(LW), .ADDR_W(AW), .PRIO_MODE(0)
    ) u_rr (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_read(req_read), .req_write(req_write),
        .req_rdata(req_rdata), .req_resp(req_resp),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy), .grant_id(grant_id)
    );

    pmem_rr_arbiter #(
        .NUM_PORTS(N), .LINE_W(LW), .ADDR_W(AW), .PRIO_MODE(1)
    ) u_fx (
        .clk(clk), .rst(rst),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .req_read(f_req_read), .req_write(f_req_write),
        .req_rdata(f_req_rdata), .req_resp(f_req_resp),
        .pmem_address(f_pmem_address), .pmem_wdata(f_pmem_wdata),
        .pmem_read(f_pmem_read), .pmem_write(f_pmem_write),
        .pmem_rdata(f_pmem_rdata), .pmem_resp(f_pmem_resp),
        .busy(f_busy), .grant_id(f_grant_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one outstanding transaction, pointer arithmetic mod N.
    bit          m_busy;
    int          m_g;
    int          m_ptr;
    int          m_lat;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    bit          m_wr;
    bit [N-1:0]  m_done;
    int          gq[$];

    int          fix_lat;
    bit          spur_en;
    bit          use_fix;
    logic [63:0] rd_fix;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the RR instance; entered and left at a falling edge.
    task automatic cycle();
        logic [N-1:0] exp_resp;
        bit found;
        int p;
        pmem_rdata = use_fix ? rd_fix : {$urandom, $urandom};
        if (m_busy) pmem_resp = (m_lat == 0);
        else pmem_resp = spur_en && ($urandom_range(3) == 0);
        #1;
        exp_resp = (m_busy && pmem_resp) ? N'(1 << m_g) : '0;
        chk("busy", busy, m_busy);
        chk("req_resp", req_resp, exp_resp);
        chk("req_rdata", req_rdata, pmem_rdata);
        if (m_busy) begin
            chk("grant_id", grant_id, m_g);
            chk("pmem_address", pmem_address, m_addr);
            chk("pmem_wdata", pmem_wdata, m_wdata);
            chk("pmem_read", pmem_read, !m_wr);
            chk("pmem_write", pmem_write, m_wr);
        end else begin
            chk("idle_strobes", {pmem_read, pmem_write}, 2'b00);
        end
        if (m_busy) begin
            if (pmem_resp) begin
                m_busy = 0;
                m_done[m_g] = 1'b1;
                m_ptr = (m_g + 1) % N;
            end else begin
                m_lat--;
            end
        end else begin
            found = 0;
            for (int d = 0; d < N; d++) begin
                p = (m_ptr + d) % N;
                if (!found && (req_read[p] || req_write[p])) begin
                    found = 1;
                    m_g = p;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_addr  = req_addr[m_g*AW +: AW];
                m_wdata = req_wdata[m_g*LW +: LW];
                m_wr    = req_write[m_g];
                m_lat   = (fix_lat >= 0) ? fix_lat : $urandom_range(3);
                gq.push_back(m_g);
            end
        end
        @(negedge clk);
    endtask

    task automatic retire();
        for (int p = 0; p < N; p++) begin
            if (m_done[p]) begin
                req_read[p]  = 1'b0;
                req_write[p] = 1'b0;
            end
        end
        m_done = '0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cycle();
            retire();
        end
    endtask

    task automatic do_reset();
        req_read  = '0;
        req_write = '0;
        pmem_resp = 1'b0;
        rst = 1'b1;
        #1;
        m_busy = 0;
        m_ptr  = 0;
        m_done = '0;
        @(negedge clk);
        rst = 1'b0;
        gq.delete();
    endtask

    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int fq[$];
    int op;
    bit drop_next;

    initial begin
        req_addr = '0; req_wdata = '0; req_read = '0; req_write = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        f_req_addr = '0; f_req_wdata = '0; f_req_read = '0;
        f_req_write = '0; f_pmem_rdata = '0; f_pmem_resp = 1'b0;
        m_busy = 0; m_ptr = 0; m_done = '0; m_g = 0; m_lat = 0;
        m_addr = '0; m_wdata = '0; m_wr = 0;
        fix_lat = -1; spur_en = 0; use_fix = 0; rd_fix = '0;

        #2 rst = 1'b1;
        #2;
        chk("rst_read", pmem_read, 1'b0);
        chk("rst_write", pmem_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_addr", pmem_address, 32'd0);
        chk("rst_wdata", pmem_wdata, 64'd0);
        chk("rst_resp", req_resp, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single read on port 1, answered in the fifth busy cycle.
        req_addr[1*AW +: AW] = 32'h0000_1040;
        req_read[1] = 1'b1;
        fix_lat = 4; use_fix = 1; rd_fix = {8{8'hA5}};
        run(8);
        use_fix = 0;
        chk("single_grants", gq.size(), 1);

        // Read on 0 and write on 1 together: 0 first, then the write.
        do_reset();
        req_addr[0*AW +: AW] = 32'h2000;
        req_addr[1*AW +: AW] = 32'h3000;
        req_wdata[1*LW +: LW] = {$urandom, $urandom};
        req_read[0] = 1'b1;
        req_write[1] = 1'b1;
        req_read[1] = 1'b1;
        fix_lat = 1;
        run(10);
        chk("rw_count", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("rw_first", gq[0], 0);
            chk("rw_second", gq[1], 1);
        end

        // Address change during service must not reach memory.
        do_reset();
        req_addr[0*AW +: AW] = 32'h100;
        req_read[0] = 1'b1;
        fix_lat = 3;
        run(2);
        req_addr[0*AW +: AW] = 32'h200;
        run(5);

        // Reset mid-transaction abandons it and restores the pointer.
        do_reset();
        req_read[2] = 1'b1;
        fix_lat = 0;
        run(4);
        req_read[1] = 1'b1;
        req_read[3] = 1'b1;
        fix_lat = 5;
        run(2);
        chk("pre_rst_grant", grant_id, 2'd3);
        #2;
        rst = 1'b1;
        pmem_resp = 1'b1;
        #1;
        chk("arst_read", pmem_read, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_resp", req_resp, 4'd0);
        chk("arst_grant", grant_id, 2'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_resp", req_resp, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        pmem_resp = 1'b0;
        m_busy = 0; m_ptr = 0; m_done = '0;
        gq.delete();
        fix_lat = 1;
        run(12);
        chk("arst_regrant", (gq.size() > 0) ? gq[0] : -1, 1);

        // All four ports requesting without pause.
        do_reset();
        for (int p = 0; p < N; p++) req_addr[p*AW +: AW] = $urandom;
        req_read = 4'hF;
        fix_lat = 0;
        for (int c = 0; c < 40 && gq.size() < 5; c++) begin
            cycle();
            for (int p = 0; p < N; p++)
                if (m_done[p]) req_addr[p*AW +: AW] = $urandom;
            m_done = '0;
        end
        chk("rr4_count", gq.size() >= 5, 1'b1);
        if (gq.size() >= 5)
            for (int i = 0; i < 5; i++) chk("rr4_order", gq[i], exp_ord[i]);

        // Randomized traffic with stray memory responses while idle.
        do_reset();
        fix_lat = -1;
        spur_en = 1;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (m_done[p]) begin
                    req_read[p] = 1'b0;
                    req_write[p] = 1'b0;
                end
                if (!(req_read[p] || req_write[p]) &&
                    $urandom_range(2) == 0) begin
                    req_addr[p*AW +: AW]  = $urandom;
                    req_wdata[p*LW +: LW] = {$urandom, $urandom};
                    op = $urandom_range(3, 1);
                    req_read[p]  = op[0];
                    req_write[p] = op[1];
                end
            end
            m_done = '0;
            cycle();
        end
        spur_en = 0;
        chk("rand_activity", gq.size() > 50, 1'b1);
        req_read = '0;
        req_write = '0;

        // Fixed priority: port 0 starves port 2 until it lets go.
        do_reset();
        f_req_addr[0*AW +: AW] = 32'h2000;
        f_req_addr[2*AW +: AW] = 32'h2200;
        f_req_read = 4'b0101;
        drop_next = 0;
        for (int c = 0; c < 60 && fq.size() < 5; c++) begin
            f_pmem_resp = f_pmem_read | f_pmem_write;
            f_pmem_rdata = {$urandom, $urandom};
            #1;
            chk("fx_rdata", f_req_rdata, f_pmem_rdata);
            if (f_req_resp != '0) begin
                chk("fx_onehot", $onehot(f_req_resp), 1'b1);
                for (int p = 0; p < N; p++)
                    if (f_req_resp[p]) fq.push_back(p);
                if (fq.size() == 4) drop_next = 1;
            end
            @(negedge clk);
            if (drop_next) f_req_read[0] = 1'b0;
        end
        f_pmem_resp = 1'b0;
        f_req_read = '0;
        chk("fx_count", fq.size() >= 5, 1'b1);
        if (fq.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk("fx_port0", fq[i], 0);
            chk("fx_port2", fq[4], 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pmem_rr_arbiter.md
PMEM_RR_ARBITER -- requirements
Module: pmem_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of cache-line requesters (2..8).
REQ-002 Parameter LINE_W, default 256, cache-line data width in bits.
REQ-003 Parameter ADDR_W, default 32, address width in bits.
REQ-004 Parameter PRIO_MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed (port 0 highest).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_addr  input  NUM_PORTS*ADDR_W  per-port line address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  input  NUM_PORTS*LINE_W  per-port write line, same packing.
REQ-009 req_read  input  NUM_PORTS  per-port read request, held until that port's resp.
REQ-010 req_write  input  NUM_PORTS  per-port write request, held until that port's resp.
REQ-011 req_rdata  output  LINE_W  read line, shared by all ports, valid only with a resp.
REQ-012 req_resp  output  NUM_PORTS  per-port one-cycle completion strobe.
REQ-013 pmem_address  output  ADDR_W  memory line address, registered.
REQ-014 pmem_wdata  output  LINE_W  memory write line, registered.
REQ-015 pmem_read  output  1  memory read strobe, registered.
REQ-016 pmem_write  output  1  memory write strobe, registered.
REQ-017 pmem_rdata  input  LINE_W  memory read line.
REQ-018 pmem_resp  input  1  memory completion, single cycle.
REQ-019 busy  output  1  high while a transaction is outstanding.
REQ-020 grant_id  output  $clog2(NUM_PORTS) (min 1)  index of the port being served; registered.

Function
REQ-021 The block SHALL implement two states, IDLE and BUSY.
REQ-022 A port is requesting when req_read[i] | req_write[i] and resp is not being returned to it this cycle.
REQ-023 In IDLE with at least one requester, the block SHALL select a winner, latch its address, wdata, and op into pmem_* registers, set grant_id, and enter BUSY on the same edge.
REQ-024 Latency: request visible in cycle 0 in IDLE -> pmem_read/pmem_write high from cycle 1.
REQ-025 If req_read and req_write are both high on one port, the write SHALL win; pmem_read=0, pmem_write=1.
REQ-026 In BUSY, pmem_* registers SHALL hold constant; input changes are ignored.
REQ-027 In BUSY with pmem_resp=1, the block SHALL assert req_resp[grant_id] combinationally in the same cycle.
REQ-028 On that edge, the block SHALL clear pmem_read/pmem_write and return to IDLE.
REQ-029 req_rdata SHALL equal pmem_rdata at all times; no registering.
REQ-030 At most one req_resp bit SHALL be high in any cycle; none in IDLE.
REQ-031 PRIO_MODE=0: search order SHALL start at rr_ptr and wrap modulo NUM_PORTS; lowest distance wins.
REQ-032 On each completion, rr_ptr SHALL become (grant_id+1) mod NUM_PORTS; it is unchanged otherwise.
REQ-033 PRIO_MODE=1: the lowest-index requester SHALL win; rr_ptr is unused.
REQ-034 Minimum spacing SHALL be one IDLE cycle between transactions; pmem strobes are low for at least one cycle between grants.
REQ-035 pmem_resp while in IDLE SHALL be ignored, with no resp and no state change.
REQ-036 busy SHALL equal (state==BUSY).

Reset
REQ-037 rst=1 SHALL immediately, without a clock, force state=IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, grant_id=0, rr_ptr=0.
REQ-038 An outstanding transaction SHALL be abandoned on reset; no req_resp is issued for it, and requesters re-arbitrate after release.
REQ-039 The first grant after reset SHALL follow rr_ptr=0.

Verification
REQ-040 Single read, port 1, addr 0x0000_1040: pmem_read=1 with pmem_address=0x1040 in cycle 1; pmem_resp in cycle 5 with rdata 0xA5.. -> req_resp=2'b10 and req_rdata=0xA5.. in cycle 5; busy=0 in cycle 6.
REQ-041 Simultaneous read on port 0 and write on port 1 after reset, RR mode: port 0 is served first, then port 1 with pmem_write=1 and the latched wdata; rr_ptr is 1 then 0.
REQ-042 NUM_PORTS=4, all ports requesting continuously, RR mode: grant order 0,1,2,3,0; each port gets a resp before any port gets its second.
REQ-043 PRIO_MODE=1, ports 0 and 2 requesting continuously: port 0 is served repeatedly and port 2 is starved; port 2 is granted once port 0 drops its request.
REQ-044 Mid-BUSY, port 0 changes addr from 0x100 to 0x200: pmem_address stays 0x100 until resp.
REQ-045 rst pulsed high mid-BUSY, between clock edges: pmem_read drops at once; no req_resp; after release, re-grant follows rr_ptr=0.
